// File: rtl/spi_pkg.sv
// spi_pkg
//   Shared definitions for the SPI master/slave pair: bit positions inside the
//   SPI_CTRL and SPI_STATUS registers, the frame-length field width, and the
//   protocol state enum. Imported by spi_logic_slave and spi_logic_master.
package spi_pkg;

  // SPI_CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_CPOL   = 1;
  localparam int CTRL_CPHA   = 2;
  localparam int CTRL_LSBF   = 3;
  localparam int CTRL_LEN_LO = 4;
  localparam int CTRL_LEN_HI = 8;
  localparam int CTRL_W      = CTRL_LEN_HI + 1;
  localparam int LEN_W       = CTRL_LEN_HI - CTRL_LEN_LO + 1;

  // SPI_STATUS bit positions
  localparam int STAT_BUSY  = 0;
  localparam int STAT_RXV   = 1;
  localparam int STAT_OVR   = 2;
  localparam int STATUS_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } spi_state_t;

  // Position in the receive register where the bit with index cnt (0 = first
  // on the wire) is stored for a frame of length len+1.
  function automatic logic [LEN_W-1:0] rx_bit_index(input logic lsbf,
                                                    input logic [LEN_W-1:0] len,
                                                    input logic [LEN_W-1:0] cnt);
    return lsbf ? cnt : (len - cnt);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
//   Brings one asynchronous pin into the clk domain through SYNC_STAGES flops,
//   then keeps one history flop so rising/falling edges can be detected by
//   comparing the history with the last synchronizer stage.
//
// Ports
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   din    in   asynchronous pin
//   level  out  synchronized pin level
//   rise   out  one-cycle pulse on a detected 0->1 transition
//   fall   out  one-cycle pulse on a detected 1->0 transition
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Reset value matches the pin's idle level so no edge is reported right
  // after reset when the pin simply sits at its inactive state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_logic_slave.sv
// spi_logic_slave
//   SPI responder running entirely in the clk_cpu domain. SCK/SS/MOSI are
//   oversampled through synchronizers; the slave shifts a CPU-supplied word
//   out on MISO while capturing MOSI. All four CPOL/CPHA modes, 1..32-bit
//   frames and MSB/LSB-first order are supported. Back-to-back frames under a
//   single SS low are handled by reloading SPI_DATA_OUT after each frame.
//
// Ports
//   clk_cpu       in   system clock
//   rst           in   synchronous active-high reset
//   SPI_CTRL      in   [0] enable [1] CPOL [2] CPHA [3] LSB-first [8:4] len-1
//   SPI_DATA_OUT  in   word to transmit, sampled at frame start
//   SPI_DATA_IN   out  last received frame, right-aligned
//   SPI_RX_ACK    in   one-cycle pulse clearing rx_valid and overrun
//   SPI_STATUS    out  [0] busy [1] rx_valid [2] overrun
//   SCK, SS, MOSI in   asynchronous SPI pins (SS active low)
//   MISO          out  serial data out
//   MISO_OE       out  MISO drive enable while selected
//   IRQ_SPI       out  one-cycle frame-complete pulse
module spi_logic_slave #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_cpu,
  input  logic              rst,
  input  logic [8:0]        SPI_CTRL,
  input  logic [DATA_W-1:0] SPI_DATA_OUT,
  output logic [DATA_W-1:0] SPI_DATA_IN,
  input  logic              SPI_RX_ACK,
  output logic [2:0]        SPI_STATUS,
  input  logic              SCK,
  input  logic              SS,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  output logic              IRQ_SPI
);

  import spi_pkg::*;

  logic sck_lvl, sck_rise, sck_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk_cpu), .rst(rst), .din(SCK),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  // SS idles high, so its synchronizer resets high.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk_cpu), .rst(rst), .din(SS),
    .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk_cpu), .rst(rst), .din(MOSI),
    .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_state_t        state;
  logic              cpol_q, cpha_q, lsbf_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [LEN_W:0]    bit_cnt;
  logic [DATA_W-1:0] data_in_q;
  logic              active_q, miso_q, irq_q, rx_valid_q, overrun_q;

  logic              enable;
  logic              lead_evt, trail_evt, sample_evt, shift_evt;
  logic              frame_start;
  logic              cfg_cpha, cfg_lsbf;
  logic [LEN_W-1:0]  cfg_len;
  logic [DATA_W-1:0] tx_load;
  logic              first_bit;
  logic [LEN_W-1:0]  rx_idx;

  // Enable is honoured live so clearing it aborts a frame in progress; every
  // other control field comes from the copy latched at frame start.
  always_comb begin
    enable     = SPI_CTRL[CTRL_EN];
    lead_evt   = cpol_q ? sck_fall : sck_rise;
    trail_evt  = cpol_q ? sck_rise : sck_fall;
    sample_evt = cpha_q ? trail_evt : lead_evt;
    shift_evt  = cpha_q ? lead_evt  : trail_evt;
    rx_idx     = rx_bit_index(lsbf_q, len_q, bit_cnt[LEN_W-1:0]);
  end

  // A frame starts either from IDLE on an SS fall (fresh config from
  // SPI_CTRL) or straight out of DONE while SS is still low (config kept).
  // For CPHA=0 the first bit goes out immediately, so the shifter is loaded
  // already advanced by one position.
  always_comb begin
    frame_start = enable && (((state == ST_IDLE) && ss_fall) ||
                             ((state == ST_DONE) && !ss_lvl));
    cfg_cpha    = (state == ST_IDLE) ? SPI_CTRL[CTRL_CPHA] : cpha_q;
    cfg_lsbf    = (state == ST_IDLE) ? SPI_CTRL[CTRL_LSBF] : lsbf_q;
    cfg_len     = (state == ST_IDLE) ? SPI_CTRL[CTRL_LEN_HI:CTRL_LEN_LO] : len_q;
    first_bit   = cfg_lsbf ? SPI_DATA_OUT[0] : SPI_DATA_OUT[cfg_len];
    if (cfg_cpha) begin
      tx_load = SPI_DATA_OUT;
    end else begin
      tx_load = cfg_lsbf ? (SPI_DATA_OUT >> 1) : (SPI_DATA_OUT << 1);
    end
  end

  // Protocol FSM. Ack is applied first so that a DONE in the same cycle
  // overrides it; overrun looks at rx_valid as it was before the ack.
  // With CPHA=0 a shift edge seen at count 0 is the trailing edge left over
  // from the previous back-to-back frame and must not consume a bit.
  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      state      <= ST_IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsbf_q     <= 1'b0;
      len_q      <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      bit_cnt    <= '0;
      data_in_q  <= '0;
      active_q   <= 1'b0;
      miso_q     <= 1'b0;
      irq_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if (SPI_RX_ACK) begin
        rx_valid_q <= 1'b0;
        overrun_q  <= 1'b0;
      end
      if (!enable) begin
        state    <= ST_IDLE;
        active_q <= 1'b0;
        miso_q   <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
          end
          ST_ACTIVE: begin
            if (ss_rise) begin
              state    <= ST_IDLE;
              active_q <= 1'b0;
              miso_q   <= 1'b0;
            end else begin
              if (shift_evt && (cpha_q || (bit_cnt != '0))) begin
                miso_q   <= lsbf_q ? tx_shift[0] : tx_shift[len_q];
                tx_shift <= lsbf_q ? (tx_shift >> 1) : (tx_shift << 1);
              end
              if (sample_evt) begin
                rx_shift[rx_idx] <= mosi_lvl;
                bit_cnt          <= bit_cnt + 6'd1;
                if (bit_cnt == {1'b0, len_q}) begin
                  state <= ST_DONE;
                end
              end
            end
          end
          ST_DONE: begin
            data_in_q  <= rx_shift;
            irq_q      <= 1'b1;
            rx_valid_q <= 1'b1;
            overrun_q  <= rx_valid_q | (overrun_q & ~SPI_RX_ACK);
            if (ss_lvl) begin
              state    <= ST_IDLE;
              active_q <= 1'b0;
              miso_q   <= 1'b0;
            end
          end
          default: begin
            state    <= ST_IDLE;
            active_q <= 1'b0;
            miso_q   <= 1'b0;
          end
        endcase
        if (frame_start) begin
          state    <= ST_ACTIVE;
          active_q <= 1'b1;
          tx_shift <= tx_load;
          rx_shift <= '0;
          bit_cnt  <= '0;
          if (!cfg_cpha) begin
            miso_q <= first_bit;
          end
          if (state == ST_IDLE) begin
            cpol_q <= SPI_CTRL[CTRL_CPOL];
            cpha_q <= SPI_CTRL[CTRL_CPHA];
            lsbf_q <= SPI_CTRL[CTRL_LSBF];
            len_q  <= SPI_CTRL[CTRL_LEN_HI:CTRL_LEN_LO];
          end
        end
      end
    end
  end

  assign SPI_DATA_IN           = data_in_q;
  assign SPI_STATUS[STAT_BUSY] = active_q;
  assign SPI_STATUS[STAT_RXV]  = rx_valid_q;
  assign SPI_STATUS[STAT_OVR]  = overrun_q;
  assign MISO                  = miso_q;
  assign MISO_OE               = active_q;
  assign IRQ_SPI               = irq_q;

endmodule

// File: tb/tb_spi_logic_slave.sv
// tb_spi_logic_slave
//   Bench for spi_logic_slave. A behavioural SPI master drives the pins with
//   SCK half-periods of several clk_cpu cycles; expected receive data and the
//   MISO bit sequence come from a bit-ordering model of the wire protocol.
module tb_spi_logic_slave;

  localparam int HALF  = 6;
  localparam int SETUP = 6;

  typedef struct {
    logic        cpol;
    logic        cpha;
    logic        lsbf;
    int          n;
    logic [31:0] dout;
    logic [31:0] mosi;
    logic [31:0] exp_rx;
    logic [31:0] exp_miso;
  } vec_t;

  logic        clk_cpu = 1'b0;
  logic        rst;
  logic [8:0]  SPI_CTRL;
  logic [31:0] SPI_DATA_OUT;
  logic [31:0] SPI_DATA_IN;
  logic        SPI_RX_ACK;
  logic [2:0]  SPI_STATUS;
  logic        SCK, SS, MOSI;
  logic        MISO, MISO_OE, IRQ_SPI;

  int checks   = 0;
  int failures = 0;
  int irq_count = 0;

  spi_logic_slave #(.DATA_W(32), .SYNC_STAGES(2)) dut (
    .clk_cpu(clk_cpu), .rst(rst),
    .SPI_CTRL(SPI_CTRL), .SPI_DATA_OUT(SPI_DATA_OUT), .SPI_DATA_IN(SPI_DATA_IN),
    .SPI_RX_ACK(SPI_RX_ACK), .SPI_STATUS(SPI_STATUS),
    .SCK(SCK), .SS(SS), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE), .IRQ_SPI(IRQ_SPI)
  );

  always #5 clk_cpu = ~clk_cpu;

  // Count completion pulses, sampled away from the active edge.
  always @(negedge clk_cpu) begin
    if (IRQ_SPI) irq_count++;
  end

  // Wire-order model: a master sending MSB-first produces bit w[n-1-i] as the
  // i-th bit on the wire. MSB-first assembly keeps the word as is (masked to
  // n bits); LSB-first assembly reverses the n-bit field. The same rule maps
  // SPI_DATA_OUT to the MISO sequence recorded first-bit-at-top.
  function automatic logic [31:0] reorder(input logic [31:0] w, input int n, input logic lsbf);
    logic [63:0] mask;
    logic [31:0] r;
    mask = (64'd1 << n) - 64'd1;
    r = w & mask[31:0];
    if (lsbf) begin
      r = '0;
      for (int i = 0; i < n; i++) r[i] = w[n-1-i];
    end
    return r;
  endfunction

  task automatic waitCycles(input int k);
    repeat (k) @(negedge clk_cpu);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pulseAck();
    @(negedge clk_cpu);
    SPI_RX_ACK = 1'b1;
    @(negedge clk_cpu);
    SPI_RX_ACK = 1'b0;
    waitCycles(2);
  endtask

  // Behavioural master: sends n bits of word MSB-first and records MISO just
  // before each of its own sample edges. start_ss/end_ss allow chaining
  // frames under one SS low.
  task automatic applyStimulus(input logic [31:0] word, input int n, input logic cpol,
                               input logic cpha, input bit start_ss, input bit end_ss,
                               output logic [31:0] seq);
    seq = '0;
    if (start_ss) begin
      @(negedge clk_cpu);
      SCK = cpol;
      waitCycles(8);
      MOSI = cpha ? 1'b0 : word[n-1];
      SS = 1'b0;
      waitCycles(SETUP);
    end else begin
      @(negedge clk_cpu);
      MOSI = cpha ? 1'b0 : word[n-1];
      waitCycles(HALF);
    end
    for (int i = 0; i < n; i++) begin
      if (!cpha) begin
        seq = {seq[30:0], MISO};
        SCK = ~cpol;
        waitCycles(HALF);
        SCK = cpol;
        if (i < n - 1) MOSI = word[n-2-i];
        waitCycles(HALF);
      end else begin
        SCK = ~cpol;
        MOSI = word[n-1-i];
        waitCycles(HALF);
        seq = {seq[30:0], MISO};
        SCK = cpol;
        waitCycles(HALF);
      end
    end
    if (end_ss) SS = 1'b1;
  endtask

  task automatic runVector(input vec_t v, input string tag);
    logic [31:0] seq;
    logic [4:0]  len5;
    int          irq_before;
    len5 = 5'(v.n - 1);
    @(negedge clk_cpu);
    SPI_CTRL     = {len5, v.lsbf, v.cpha, v.cpol, 1'b1};
    SPI_DATA_OUT = v.dout;
    irq_before   = irq_count;
    applyStimulus(v.mosi, v.n, v.cpol, v.cpha, 1'b1, 1'b1, seq);
    waitCycles(6);
    checkOutput($sformatf("%s_rx", tag), SPI_DATA_IN, v.exp_rx);
    checkOutput($sformatf("%s_miso", tag), seq, v.exp_miso);
    checkOutput($sformatf("%s_irq", tag), 32'(irq_count - irq_before), 32'd1);
    checkOutput($sformatf("%s_status", tag), {29'd0, SPI_STATUS}, 32'h2);
    pulseAck();
    checkOutput($sformatf("%s_ack", tag), {29'd0, SPI_STATUS}, 32'h0);
  endtask

  vec_t vectors[6];

  initial begin
    logic [31:0] seq;
    int          irq_before;
    vec_t        rv;

    vectors[0] = '{1'b0, 1'b0, 1'b0, 8,  32'h000000A5, 32'h09,       32'h09,       32'hA5};
    vectors[1] = '{1'b1, 1'b1, 1'b1, 8,  32'h00000001, 32'hA9,       32'h95,       32'h80};
    vectors[2] = '{1'b0, 1'b0, 1'b0, 32, 32'h80000001, 32'hDEADBEEF, 32'hDEADBEEF, 32'h80000001};
    vectors[3] = '{1'b1, 1'b0, 1'b0, 1,  32'h00000001, 32'h1,        32'h1,        32'h1};
    vectors[4] = '{1'b0, 1'b1, 1'b0, 12, 32'h00000ABC, 32'h5A3,      32'h5A3,      32'hABC};
    vectors[5] = '{1'b1, 1'b0, 1'b1, 16, 32'h00001234, 32'h00F1,     32'h8F00,     32'h2C48};

    rst = 1'b1;
    SPI_CTRL = '0;
    SPI_DATA_OUT = '0;
    SPI_RX_ACK = 1'b0;
    SCK = 1'b0;
    SS = 1'b1;
    MOSI = 1'b0;
    waitCycles(4);
    checkOutput("reset_data_in", SPI_DATA_IN, 32'h0);
    checkOutput("reset_status", {29'd0, SPI_STATUS}, 32'h0);
    checkOutput("reset_pins", {29'd0, MISO, MISO_OE, IRQ_SPI}, 32'h0);
    rst = 1'b0;
    waitCycles(8);

    for (int i = 0; i < 6; i++) begin
      runVector(vectors[i], $sformatf("vec%0d", i));
    end

    for (int k = 0; k < 10; k++) begin
      rv.cpol = 1'($urandom_range(0, 1));
      rv.cpha = 1'($urandom_range(0, 1));
      rv.lsbf = 1'($urandom_range(0, 1));
      rv.n    = int'($urandom_range(1, 32));
      rv.dout = $urandom;
      rv.mosi = $urandom;
      rv.exp_rx   = reorder(rv.mosi, rv.n, rv.lsbf);
      rv.exp_miso = reorder(rv.dout, rv.n, rv.lsbf);
      runVector(rv, $sformatf("rnd%0d", k));
    end

    // Two frames under one SS low without an ack in between.
    @(negedge clk_cpu);
    SPI_CTRL = 9'b001110001;
    SPI_DATA_OUT = 32'hA5;
    irq_before = irq_count;
    applyStimulus(32'h12, 8, 1'b0, 1'b0, 1'b1, 1'b0, seq);
    checkOutput("b2b_miso1", seq, 32'hA5);
    applyStimulus(32'h34, 8, 1'b0, 1'b0, 1'b0, 1'b1, seq);
    checkOutput("b2b_miso2", seq, 32'hA5);
    waitCycles(6);
    checkOutput("b2b_irq", 32'(irq_count - irq_before), 32'd2);
    checkOutput("b2b_rx", SPI_DATA_IN, 32'h34);
    checkOutput("b2b_status", {29'd0, SPI_STATUS}, 32'h6);
    pulseAck();
    checkOutput("b2b_ack", {29'd0, SPI_STATUS}, 32'h0);

    // SS raised after 5 of 8 bits.
    irq_before = irq_count;
    applyStimulus(32'h1F, 5, 1'b0, 1'b0, 1'b1, 1'b1, seq);
    waitCycles(4);
    checkOutput("abort_busy_oe", {30'd0, SPI_STATUS[0], MISO_OE}, 32'h0);
    waitCycles(6);
    checkOutput("abort_irq", 32'(irq_count - irq_before), 32'd0);
    checkOutput("abort_rx", SPI_DATA_IN, 32'h34);
    checkOutput("abort_status", {29'd0, SPI_STATUS}, 32'h0);

    // Enable cleared mid-frame.
    irq_before = irq_count;
    SCK = 1'b0;
    waitCycles(8);
    SS = 1'b0;
    waitCycles(SETUP);
    SCK = 1'b1;
    waitCycles(HALF);
    SCK = 1'b0;
    waitCycles(HALF);
    checkOutput("en_abort_started", {31'd0, SPI_STATUS[0]}, 32'h1);
    SPI_CTRL[0] = 1'b0;
    waitCycles(2);
    checkOutput("en_abort_busy_oe", {30'd0, SPI_STATUS[0], MISO_OE}, 32'h0);
    checkOutput("en_abort_irq", 32'(irq_count - irq_before), 32'd0);
    SS = 1'b1;
    SPI_CTRL[0] = 1'b1;
    waitCycles(8);

    // Reset asserted in the middle of a frame, then a fresh frame.
    SS = 1'b0;
    waitCycles(SETUP);
    SCK = 1'b1;
    waitCycles(HALF);
    SCK = 1'b0;
    waitCycles(HALF);
    SCK = 1'b1;
    waitCycles(3);
    checkOutput("rst_mid_started", {31'd0, SPI_STATUS[0]}, 32'h1);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("rst_mid_data_in", SPI_DATA_IN, 32'h0);
    checkOutput("rst_mid_status", {29'd0, SPI_STATUS}, 32'h0);
    checkOutput("rst_mid_pins", {29'd0, MISO, MISO_OE, IRQ_SPI}, 32'h0);
    SS = 1'b1;
    SCK = 1'b0;
    waitCycles(2);
    rst = 1'b0;
    waitCycles(8);
    runVector(vectors[0], "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
